// File: rtl/painel_display.sv
// painel_display: 4-digit multiplexed active-low 7-segment panel showing controller state mnemonic and reservoir level
module painel_display #(
   parameter int REFRESH_DIV = 4,
   parameter int BLINK_DIV   = 8,
   parameter int HOLD_CYCLES = 16
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] estado,
   input  logic [3:0] reservatorio,
   input  logic       bomba,
   input  logic       termobloco,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);
   localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
   localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);
   localparam logic [BW-1:0] BLK_LAST  = BW'(BLINK_DIV - 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);
   localparam logic [6:0] G_A = 7'b0001000, G_C = 7'b1000110, G_E = 7'b0000110, G_F = 7'b0001110;
   localparam logic [6:0] G_H = 7'b0001001, G_P = 7'b0001100, G_R = 7'b0101111, G_5 = 7'b0010010;
   localparam logic [6:0] G_DASH = 7'b0111111, G_BLANK = 7'b1111111;

   logic [RW-1:0] ref_q, ref_d;
   logic [BW-1:0] blk_q, blk_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [1:0]    idx_q, idx_d;
   logic [3:0]    prev_q;
   logic          phase_q, phase_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic          ref_wrap, blk_wrap, blink_act, blank_lvl, off;
   logic [13:0]   letters;
   logic [3:0]    tens, units;
   logic [6:0]    sel;

   function automatic logic [6:0] digit7(input logic [3:0] v);
      case (v)
         4'd0:    digit7 = 7'b1000000;
         4'd1:    digit7 = 7'b1111001;
         4'd2:    digit7 = 7'b0100100;
         4'd3:    digit7 = 7'b0110000;
         4'd4:    digit7 = 7'b0011001;
         4'd5:    digit7 = 7'b0010010;
         4'd6:    digit7 = 7'b0000010;
         4'd7:    digit7 = 7'b1111000;
         4'd8:    digit7 = 7'b0000000;
         4'd9:    digit7 = 7'b0010000;
         default: digit7 = G_BLANK;
      endcase
   endfunction

   function automatic logic [13:0] mnem(input logic [3:0] e);
      case (e)
         4'd1:    mnem = {G_H, G_E};
         4'd2:    mnem = {G_P, G_R};
         4'd3:    mnem = {G_E, G_R};
         4'd4:    mnem = {G_5, G_E};
         4'd5:    mnem = {G_C, G_A};
         4'd6:    mnem = {G_R, G_F};
         default: mnem = {G_DASH, G_DASH};
      endcase
   endfunction

   always_comb begin
      ref_wrap  = ref_q == REF_LAST;
      ref_d     = ref_wrap ? '0 : ref_q + 1'b1;
      idx_d     = ref_wrap ? idx_q + 2'd1 : idx_q;
      blink_act = (estado != 4'd0 && reservatorio == 4'd0) || estado == 4'd6;
      blk_wrap  = blk_q == BLK_LAST;
      blk_d     = (!blink_act || blk_wrap) ? '0 : blk_q + 1'b1;
      phase_d   = !blink_act ? 1'b1 : (blk_wrap ? ~phase_q : phase_q);
      // a fresh entry into the wrong-code state (re)arms the hold; OFF cancels it outright
      hold_d    = estado == 4'd0 ? '0 :
                  (estado == 4'd3 && prev_q != 4'd3) ? HOLD_LOAD :
                  hold_q != '0 ? hold_q - 1'b1 : hold_q;
      letters   = hold_q != '0 ? {G_E, G_R} : mnem(estado);
      tens      = reservatorio >= 4'd10 ? 4'd1 : 4'd0;
      units     = reservatorio >= 4'd10 ? reservatorio - 4'd10 : reservatorio;
      blank_lvl = blink_act && !phase_q;
      sel       = idx_q == 2'd3 ? letters[13:7] :
                  idx_q == 2'd2 ? letters[6:0] :
                  blank_lvl ? G_BLANK : digit7(idx_q == 2'd1 ? tens : units);
      off       = estado == 4'd0;
      an_d      = off ? 4'b1111 : ~(4'b0001 << idx_q);
      seg_d     = off ? G_BLANK : sel;
      dp_d      = off ? 1'b1 : !((idx_q == 2'd2 && bomba) || (idx_q == 2'd0 && termobloco));
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ref_q   <= '0;
         idx_q   <= '0;
         blk_q   <= '0;
         phase_q <= 1'b1;
         hold_q  <= '0;
         prev_q  <= '0;
         an_q    <= 4'b1111;
         seg_q   <= G_BLANK;
         dp_q    <= 1'b1;
      end else begin
         ref_q   <= ref_d;
         idx_q   <= idx_d;
         blk_q   <= blk_d;
         phase_q <= phase_d;
         hold_q  <= hold_d;
         prev_q  <= estado;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;
endmodule

// File: tb/tb_painel_display.sv
// tb_painel_display: directed checks of scan order, glyphs, dp, blink timing, error hold and OFF blanking
module tb_painel_display;
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [3:0] estado = 4'd5;
  logic [3:0] reservatorio = 4'd12;
  logic       bomba = 1'b0;
  logic       termobloco = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  int vec = 0;
  int errs = 0;
  int s = 0;
  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
  localparam logic [6:0] G7 = 7'b1111000, GA = 7'b0001000, GC = 7'b1000110, GE = 7'b0000110;
  localparam logic [6:0] GF = 7'b0001110, GH = 7'b0001001, GP = 7'b0001100, GR = 7'b0101111;
  localparam logic [6:0] GD = 7'b0111111, GB = 7'b1111111;
  always #5 CLK = ~CLK;
  painel_display #(.REFRESH_DIV(2), .BLINK_DIV(4), .HOLD_CYCLES(10)) dut (
    .CLK(CLK), .RST(RST), .estado(estado), .reservatorio(reservatorio),
    .bomba(bomba), .termobloco(termobloco), .an(an), .seg(seg), .dp(dp)
  );
  task automatic tick;
    @(negedge CLK);
    s++;
  endtask
  function automatic int cur();
    return ((s - 1) / 2) % 4;
  endfunction
  task automatic test_reset;
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;
    #1 vec++;
    if ({an, seg, dp} !== {4'b1111, GB, 1'b1}) begin
      errs++;
      $display("FAIL reset_async an=%b seg=%b dp=%b want 1111 1111111 1", an, seg, dp);
    end
    @(negedge CLK);
    vec++;
    if ({an, seg, dp} !== {4'b1111, GB, 1'b1}) begin
      errs++;
      $display("FAIL reset_held an=%b seg=%b dp=%b want 1111 1111111 1", an, seg, dp);
    end
    RST = 1'b0;
    s = 0;
  endtask
  task automatic test_scan;
    for (int k = 0; k < 10; k++) begin
      tick();
      vec++;
      if (an !== ~(4'b0001 << cur())) begin
        errs++;
        $display("FAIL scan k=%0d an=%b want %b", k, an, ~(4'b0001 << cur()));
      end
    end
  endtask
  task automatic test_mnemonic;
    logic [6:0] es[4];
    estado = 4'd1; reservatorio = 4'd12; termobloco = 1'b1; bomba = 1'b0;
    es[3] = GH; es[2] = GE; es[1] = G1; es[0] = G2;
    for (int k = 0; k < 8; k++) begin
      tick();
      vec++;
      if ({an, seg, dp} !== {~(4'b0001 << cur()), es[cur()], cur() != 0}) begin
        errs++;
        $display("FAIL mnemonic_he d=%0d an=%b seg=%b dp=%b want %b %b %b", cur(), an, seg, dp,
                 ~(4'b0001 << cur()), es[cur()], cur() != 0);
      end
    end
    termobloco = 1'b0;
  endtask
  task automatic test_blink;
    logic [6:0] e;
    estado = 4'd2; reservatorio = 4'd0;
    for (int k = 0; k < 16; k++) begin
      tick();
      e = cur() == 3 ? GP : cur() == 2 ? GR : ((k / 4) % 2 == 1) ? GB : G0;
      vec++;
      if (seg !== e || dp !== 1'b1) begin
        errs++;
        $display("FAIL blink k=%0d d=%0d seg=%b dp=%b want %b 1", k, cur(), seg, dp, e);
      end
    end
    reservatorio = 4'd3;
    for (int k = 0; k < 8; k++) begin
      tick();
      e = cur() == 3 ? GP : cur() == 2 ? GR : cur() == 1 ? G0 : G3;
      vec++;
      if (seg !== e) begin
        errs++;
        $display("FAIL steady03 k=%0d d=%0d seg=%b want %b", k, cur(), seg, e);
      end
    end
  endtask
  task automatic test_hold;
    logic [6:0] e;
    estado = 4'd3;
    for (int k = 0; k < 21; k++) begin
      tick();
      if (k == 0) estado = 4'd2;
      e = cur() == 1 ? G0 : cur() == 0 ? G3 : (k <= 10) ? (cur() == 3 ? GE : GR) : (cur() == 3 ? GP : GR);
      vec++;
      if (seg !== e || an !== ~(4'b0001 << cur())) begin
        errs++;
        $display("FAIL hold k=%0d d=%0d seg=%b an=%b want %b %b", k, cur(), seg, an, e, ~(4'b0001 << cur()));
      end
    end
    estado = 4'd3;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (k == 5) begin
        vec++;
        if ({an, seg, dp} !== {4'b1111, GB, 1'b1}) begin
          errs++;
          $display("FAIL hold_off an=%b seg=%b dp=%b want 1111 1111111 1", an, seg, dp);
        end
      end else begin
        e = cur() == 1 ? G0 : cur() == 0 ? G3 : (k < 5) ? (cur() == 3 ? GE : GR) : (cur() == 3 ? GP : GR);
        vec++;
        if (seg !== e) begin
          errs++;
          $display("FAIL hold_cancel k=%0d d=%0d seg=%b want %b", k, cur(), seg, e);
        end
      end
      if (k == 0) estado = 4'd2;
      if (k == 4) estado = 4'd0;
      if (k == 5) estado = 4'd2;
    end
  endtask
  task automatic test_serve;
    logic [6:0] es[4];
    logic [6:0] e;
    estado = 4'd5; reservatorio = 4'd7; bomba = 1'b1;
    es[3] = GC; es[2] = GA; es[1] = G0; es[0] = G7;
    for (int k = 0; k < 8; k++) begin
      tick();
      vec++;
      if (seg !== es[cur()] || dp !== (cur() != 2)) begin
        errs++;
        $display("FAIL serve d=%0d seg=%b dp=%b want %b %b", cur(), seg, dp, es[cur()], cur() != 2);
      end
    end
    estado = 4'd6; bomba = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      e = cur() == 3 ? GR : cur() == 2 ? GF : ((k / 4) % 2 == 1) ? GB : cur() == 1 ? G0 : G7;
      vec++;
      if (seg !== e) begin
        errs++;
        $display("FAIL refill_blink k=%0d d=%0d seg=%b want %b", k, cur(), seg, e);
      end
    end
  endtask
  task automatic test_dash_off;
    logic [6:0] e;
    estado = 4'd9; reservatorio = 4'd7;
    for (int k = 0; k < 8; k++) begin
      tick();
      e = cur() >= 2 ? GD : cur() == 1 ? G0 : G7;
      vec++;
      if (seg !== e) begin
        errs++;
        $display("FAIL dash d=%0d seg=%b want %b", cur(), seg, e);
      end
    end
    estado = 4'd0;
    for (int k = 0; k < 6; k++) begin
      tick();
      vec++;
      if ({an, seg, dp} !== {4'b1111, GB, 1'b1}) begin
        errs++;
        $display("FAIL off k=%0d an=%b seg=%b dp=%b want 1111 1111111 1", k, an, seg, dp);
      end
    end
    estado = 4'd9;
    for (int k = 0; k < 6; k++) begin
      tick();
      e = cur() >= 2 ? GD : cur() == 1 ? G0 : G7;
      vec++;
      if (an !== ~(4'b0001 << cur()) || seg !== e) begin
        errs++;
        $display("FAIL resume k=%0d an=%b seg=%b want %b %b", k, an, seg, ~(4'b0001 << cur()), e);
      end
    end
  endtask
  initial begin
    test_reset();
    test_scan();
    test_mnemonic();
    test_blink();
    test_hold();
    test_serve();
    test_dash_off();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
